// File: rtl/uart_pkg.sv
// Shared definitions for the document UART streamer.
//   - FSM state encodings for the streamer
//   - BAUD_DIV computation
//   - ASCII constants (CR, LF, SPACE) and the 8N1 frame length
package uart_pkg;

  localparam int unsigned FRAME_BITS = 10;  // start + 8 data + stop

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;

  // Streamer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_TERM   = 3'd3;
  localparam logic [2:0] ST_SEND   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/doc_uart_streamer_if.sv
// Document RAM read port.
//   read_en   : streamer owns the port
//   read_addr : {row, col} address
//   read_data : byte at read_addr (combinational or one-cycle registered)
// master = streamer side, slave = memory side.
interface doc_uart_streamer_if #(
  parameter int ADDR_W = 9
);
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [7:0]        read_data;

  modport master (output read_en, output read_addr, input read_data);
  modport slave  (input read_en, input read_addr, output read_data);
endinterface

// File: rtl/uart_tx_frame.sv
// Single 8N1 frame transmitter.
//   clk, rst_n : clock, async active-low reset
//   start      : load data and begin a frame (accepted only when idle)
//   data       : byte to send
//   ready      : high when idle or in the final clock of the stop bit, so the
//                caller can line up the next byte without a dead cycle
//   tx         : serial line, idles high
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  active_q, active_d;
  logic                  last_cycle;

  assign last_cycle = active_q && (baud_q == '0) && (bit_q == LAST_BIT);

  always_comb begin
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (!active_q) begin
      if (start) begin
        shift_d  = {1'b1, data, 1'b0};
        baud_d   = BAUD_RELOAD;
        bit_d    = '0;
        active_d = 1'b1;
      end
    end else if (baud_q == '0) begin
      baud_d = BAUD_RELOAD;
      if (bit_q == LAST_BIT) begin
        active_d = 1'b0;
      end else begin
        bit_d   = bit_q + 1'b1;
        shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
      end
    end else begin
      baud_d = baud_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

  assign tx    = active_q ? shift_q[0] : 1'b1;
  assign ready = !active_q || last_cycle;

endmodule

// File: rtl/doc_uart_streamer.sv
// Walks a ROWS x COLS document row by row and sends each byte as UART 8N1,
// with a line terminator after every row and 8'h00 cells sent as BLANK_CHAR.
//   clk, rst_n : clock, async active-low reset
//   send       : one-cycle start request (ignored unless idle)
//   rd         : document read port (master side)
//   busy       : transfer in progress
//   done       : one-cycle pulse after the final stop bit
//   tx         : UART line, idles high
// Build option: define CRLF_EN to terminate each row with CR then EOL_CHAR.
//
// state     | meaning
// IDLE      | waiting for send
// FETCH     | read_addr driven for {row, col}
// SAMPLE    | read_data captured, blank-mapped, frame started
// TERM      | terminator byte started (no memory read)
// SEND      | frame on the line; on its last clock pick next step,
//           | including the row advance, so no gap cycle is spent on it
// DONE      | done pulse, busy low
module doc_uart_streamer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned COLS       = 32,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned ADDR_W     = 9,
  parameter logic [7:0]  EOL_CHAR   = LF,
  parameter logic [7:0]  BLANK_CHAR = SPACE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                send,
  doc_uart_streamer_if.master rd,
  output logic                busy,
  output logic                done,
  output logic                tx
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_HZ, BAUD);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

`ifdef CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic [2:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             term_q, term_d;  // frame on the line is a row terminator
  logic             lf_q, lf_d;      // CRLF: CR already sent, LF is next

  logic             frame_start;
  logic [7:0]       frame_data;
  logic             frame_ready;
  logic [7:0]       term_byte;
  logic [ADDR_W-1:0] addr;

`ifdef CRLF_EN
  assign term_byte = lf_q ? EOL_CHAR : CR;
`else
  assign term_byte = EOL_CHAR;
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    term_d      = term_q;
    lf_d        = lf_q;
    frame_start = 1'b0;
    frame_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          state_d = ST_FETCH;
          row_d   = '0;
          col_d   = '0;
          term_d  = 1'b0;
          lf_d    = 1'b0;
        end
      end
      ST_FETCH: state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        frame_start = 1'b1;
        frame_data  = (rd.read_data == 8'h00) ? BLANK_CHAR : rd.read_data;
        term_d      = 1'b0;
        state_d     = ST_SEND;
      end
      ST_TERM: begin
        frame_start = 1'b1;
        frame_data  = term_byte;
        term_d      = 1'b1;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (frame_ready) begin
          if (term_q) begin
            if (CRLF && !lf_q) begin
              lf_d    = 1'b1;
              state_d = ST_TERM;
            end else if (row_q == LAST_ROW) begin
              row_d   = '0;
              col_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + 1'b1;
              col_d   = '0;
              state_d = ST_FETCH;
            end
          end else if (col_q == LAST_COL) begin
            lf_d    = 1'b0;
            state_d = ST_TERM;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      term_q  <= 1'b0;
      lf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      term_q  <= term_d;
      lf_q    <= lf_d;
    end
  end

  uart_tx_frame #(.BAUD_DIV(BAUD_DIV)) u_frame (
    .clk   (clk),
    .rst_n (rst_n),
    .start (frame_start),
    .data  (frame_data),
    .ready (frame_ready),
    .tx    (tx)
  );

  assign addr         = {row_q, col_q};
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign rd.read_en   = busy;
  assign rd.read_addr = addr;

endmodule

// File: tb/tb_doc_uart_streamer.sv
module tb_doc_uart_streamer;
  import uart_pkg::*;

`ifdef CRLF_EN
  localparam int NF = 12;
  logic [7:0] exp_b [NF] = '{8'h41, 8'h42, 8'h20, 8'h44, 8'h0D, 8'h0A,
                             8'h45, 8'h46, 8'h47, 8'h48, 8'h0D, 8'h0A};
`else
  localparam int NF = 10;
  logic [7:0] exp_b [NF] = '{8'h41, 8'h42, 8'h20, 8'h44, 8'h0A,
                             8'h45, 8'h46, 8'h47, 8'h48, 8'h0A};
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic send = 1'b0;
  logic busy, done, tx;
  logic mem_lat = 1'b0;
  logic [7:0] rd_q = 8'h00;
  logic [7:0] mem [8] = '{8'h41, 8'h42, 8'h00, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};

  int cyc = 0;
  int done_cnt = 0;
  int n_chk = 0;
  int n_err = 0;

  doc_uart_streamer_if #(.ADDR_W(3)) rd_if ();

  doc_uart_streamer #(
    .CLK_HZ(16), .BAUD(1), .COLS(4), .ROWS(2), .ADDR_W(3),
    .EOL_CHAR(8'h0A), .BLANK_CHAR(8'h20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .send  (send),
    .rd    (rd_if),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_q <= mem[rd_if.read_addr];
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;
  assign rd_if.read_data = mem_lat ? rd_q : mem[rd_if.read_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for a start bit, then sample all 160 clocks of the frame.
  task automatic decode_frame(output logic [7:0] b, output bit good, output int t0,
                              input int poke_k);
    logic [9:0] bits;
    bit found;
    good = 1'b1; t0 = 0; b = 8'h00; found = 1'b0; bits = '0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      check("start_seen", 32'd0, 32'd1);
      good = 1'b0;
      return;
    end
    t0 = cyc;
    for (int k = 0; k < 160; k++) begin
      if (k > 0) @(negedge clk);
      if (k == poke_k) send = 1'b1;
      if (k == poke_k + 1) send = 1'b0;
      if (busy !== 1'b1) good = 1'b0;
      if (k % 16 == 0) bits[k/16] = tx;
      else if (tx !== bits[k/16]) good = 1'b0;
    end
    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) good = 1'b0;
    b = bits[8:1];
  endtask

  task automatic run_xfer(input int poke_frame, input bit send_at_done);
    logic [7:0] b;
    bit g;
    int t, t_prev, d0;
    d0 = done_cnt;
    t_prev = 0;
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    for (int i = 0; i < NF; i++) begin
      decode_frame(b, g, t, (i == poke_frame) ? 40 : -1);
      check("byte", {24'd0, b}, {24'd0, exp_b[i]});
      check("bit_timing", {31'd0, g}, 32'd1);
      if (i > 0) check("frame_gap", {31'd0, (t - t_prev >= 160) && (t - t_prev <= 162)}, 32'd1);
      t_prev = t;
    end
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    if (send_at_done) send = 1'b1;
    @(negedge clk) send = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_read_en", {31'd0, rd_if.read_en}, 32'd0);
    check("idle_addr", {29'd0, rd_if.read_addr}, 32'd0);
    check("done_once", done_cnt - d0, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    bit g;
    int t;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read_en", {31'd0, rd_if.read_en}, 32'd0);
    check("rst_addr", {29'd0, rd_if.read_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // plain transfer, framing and bit timing
    run_xfer(-1, 1'b0);

    // send during transfer and during DONE are both ignored
    run_xfer(4, 1'b1);

    // reset inside the data bits of the third frame
    @(negedge clk) send = 1'b1;
    @(negedge clk) send = 1'b0;
    for (int i = 0; i < 2; i++) begin
      decode_frame(b, g, t, -1);
      check("pre_rst_byte", {24'd0, b}, {24'd0, exp_b[i]});
    end
    decode_frame_start: begin
      bit found;
      found = 1'b0;
      for (int w = 0; w < 400; w++) begin
        @(negedge clk);
        if (tx === 1'b0) begin
          found = 1'b1;
          break;
        end
      end
      check("third_start_seen", {31'd0, found}, 32'd1);
    end
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_read_en", {31'd0, rd_if.read_en}, 32'd0);
    check("midrst_addr", {29'd0, rd_if.read_addr}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("no_resume_tx", {31'd0, tx}, 32'd1);
    check("no_resume_busy", {31'd0, busy}, 32'd0);
    run_xfer(-1, 1'b0);

    // one-cycle registered memory
    mem_lat = 1'b1;
    run_xfer(-1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
